branch_resolve_local: RTL and testbench
=======================================

// Module: branch_resolve_local
// PURPOSE
//   Consumer/return side of the local branch predictor. Carries each prediction from D through E to M.
//   Resolves the branch in E against the ALU outcome and issues a one-shot redirect on a mispredict.
//   Produces the M-stage update pulse (branchM/actual_takeM/pcM) the predictor trains on, plus saturating perf counters.
//   Sits between the decode-stage predictor output and the fetch PC mux / hazard unit.
// PARAMETERS
//   DELAY_SLOT  1   1: fall-through = pc+8 (MIPS delay slot); 0: pc+4
//   CNT_W       32  width of perf counters
// PORTS
//   clk            in   1      clock, rising edge
//   rst            in   1      synchronous, active-high reset
//   stallE         in   1      hold D->E register
//   flushE         in   1      clear D->E register (bubble)
//   stallM         in   1      hold E->M register
//   flushM         in   1      clear E->M register
//   branchD        in   1      instr in D is a conditional branch
//   pred_takeD     in   1      predictor output for instr in D
//   pcD            in   32     PC of instr in D
//   targetD        in   32     branch target computed in D
//   actual_takeE   in   1      resolved condition from ALU, valid when branchE
//   mispredictE    out  1      one-shot: branch in E resolved opposite to prediction
//   redirect_pcE   out  32     correct next fetch PC, valid with mispredictE
//   branchM        out  1      update strobe to predictor, 1 cycle per retired branch
//   actual_takeM   out  1      resolved direction for update
//   pcM            out  32     PC of branch for update indexing
//   br_cnt         out  CNT_W  branches retired
//   mispred_cnt    out  CNT_W  mispredicts retired
// BEHAVIOUR
//   - Reset: all pipeline regs 0, redirect_done=0, counters 0; hence mispredictE=0, branchM=0, actual_takeM=0, pcM=0.
//   - D->E reg {branch,pred,pc,target}: rst|flushE -> 0; else ~stallE -> load; else hold. flushE beats stallE.
//   - E: mismatch = branchE & (predE ^ actual_takeE).
//     mispredictE = mismatch & ~redirect_done (comb).
//     redirect_pcE = actual_takeE ? targetE : pcE + (DELAY_SLOT?8:4); 32-bit wrap, no carry-out.
//   - redirect_done: set when mispredictE & stallE; cleared when E reg loads or flushes. Stalled mispredict pulses exactly once.
//   - E->M reg {branch,actual,pc,mispred}: rst|flushM -> 0; else ~stallM -> load from E (branch gated by ~stallE, so a held E instr is not duplicated); else hold.
//   - branchM output = branchM_reg & ~stallM: predictor sees exactly one update per branch even under M stall.
//   - actual_takeM/pcM = register values; don't-care when branchM=0 but must not be X after reset.
//   - Counters advance on branchM pulse: br_cnt+1, mispred_cnt+1 if mispredM; saturate at all-ones, never wrap.
//   - Mispredict and flush in same cycle: mispredictE still asserted (hazard unit flushes D,F), E reg not affected by own output.
//   - Back-to-back branches: each resolves independently; redirect_done per E occupant only.
//   - Reset mid-operation: all in-flight branches dropped, no update pulse emitted that cycle.
// STRUCTURE
//   - Shared pkg: PC_W=32, FALLTHRU offsets (4/8), 2-bit predictor state encodings shared with predictor.
//   - One sub-module: sat_counter #(W) (clk,rst,inc,q), instantiated twice for perf counters.
//   - Rest is flat: two pipeline regs, redirect_done flag, comparator, target mux.
// TESTING
//   1 rst 3 cycles -> mispredictE=0, branchM=0, br_cnt=0, mispred_cnt=0.
//   2 branchD=1,pred=1,pcD=0x100,targetD=0x200; next cycle actual_takeE=1 -> mispredictE=0;
//     following cycle branchM=1, actual_takeM=1, pcM=0x100; br_cnt=1, mispred_cnt=0.
//   3 pred=0, actual=1, targetD=0x400 -> mispredictE=1, redirect_pcE=0x400; pred=1, actual=0, pcD=0x100 -> redirect_pcE=0x108.
//   4 mispredict with stallE high 3 cycles -> mispredictE high exactly 1 cycle; branchM exactly 1 pulse after release.
//   5 branchM pending with stallM high 2 cycles -> branchM=0 during stall, 1 for one cycle after; flushM during hold -> no pulse.
//   6 force mispred_cnt to 0xFFFFFFFF, retire mispredict -> stays 0xFFFFFFFF; br_cnt still increments.

Source files
------------

// File: rtl/branch_resolve_local_pkg.sv
// Shared types and constants for the local branch predictor return path.
package branch_resolve_local_pkg;
    localparam int PC_W = 32;
    localparam logic [PC_W-1:0] FALLTHRU_NODS = 32'd4;
    localparam logic [PC_W-1:0] FALLTHRU_DS   = 32'd8;

    // 2-bit saturating predictor states, shared with the predictor table
    typedef enum logic [1:0] {
        ST_SNT = 2'b00,
        ST_WNT = 2'b01,
        ST_WT  = 2'b10,
        ST_ST  = 2'b11
    } bp_state_e;

    // D->E pipeline register payload
    typedef struct packed {
        logic            branch;
        logic            pred;
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] target;
    } de_reg_t;

    // E->M pipeline register payload
    typedef struct packed {
        logic            branch;
        logic            actual;
        logic [PC_W-1:0] pc;
        logic            mispred;
    } em_reg_t;

    // Fall-through distance: skip the delay slot when one exists
    function automatic logic [PC_W-1:0] fallthru_off(input logic delay_slot);
        return delay_slot ? FALLTHRU_DS : FALLTHRU_NODS;
    endfunction
endpackage

// File: rtl/branch_resolve_local_sat_counter.sv
// Saturating up-counter used for the perf counters; sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] q
);
    logic [W-1:0] r_q;

    // Count up on inc, hold once every bit is set
    always_ff @(posedge clk) begin
        if (rst)
            r_q <= '0;
        else if (inc && (r_q != {W{1'b1}}))
            r_q <= r_q + W'(1);
    end

    assign q = r_q;
endmodule

// File: rtl/branch_resolve_local.sv
// Carries branch predictions D->E->M, resolves them in E, raises a one-shot
// redirect on mispredict and emits the M-stage predictor update pulse.
module branch_resolve_local
    import branch_resolve_local_pkg::*;
#(
    parameter int DELAY_SLOT = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallE,
    input  logic             flushE,
    input  logic             stallM,
    input  logic             flushM,
    input  logic             branchD,
    input  logic             pred_takeD,
    input  logic [PC_W-1:0]  pcD,
    input  logic [PC_W-1:0]  targetD,
    input  logic             actual_takeE,
    output logic             mispredictE,
    output logic [PC_W-1:0]  redirect_pcE,
    output logic             branchM,
    output logic             actual_takeM,
    output logic [PC_W-1:0]  pcM,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);
    de_reg_t r_de;
    em_reg_t r_em;
    logic    r_redirect_done;
    logic    w_mismatch;
    logic    w_mis_inc;

    // D->E register: flush wins over stall
    always_ff @(posedge clk) begin
        if (rst || flushE)
            r_de <= '0;
        else if (!stallE)
            r_de <= '{branch: branchD, pred: pred_takeD, pc: pcD, target: targetD};
    end

    assign w_mismatch   = r_de.branch & (r_de.pred ^ actual_takeE);
    assign mispredictE  = w_mismatch & ~r_redirect_done;
    assign redirect_pcE = actual_takeE ? r_de.target
                                       : r_de.pc + fallthru_off(DELAY_SLOT != 0);

    // Remember a redirect already issued while the E occupant is held,
    // so a stalled mispredict pulses only once; a new occupant clears it
    always_ff @(posedge clk) begin
        if (rst || flushE || !stallE)
            r_redirect_done <= 1'b0;
        else if (mispredictE)
            r_redirect_done <= 1'b1;
    end

    // E->M register: a held E instruction moves on only once, when E releases
    always_ff @(posedge clk) begin
        if (rst || flushM)
            r_em <= '0;
        else if (!stallM)
            r_em <= '{branch:  r_de.branch & ~stallE,
                      actual:  actual_takeE,
                      pc:      r_de.pc,
                      mispred: w_mismatch & ~stallE};
    end

    // One update per branch: suppress while M is held or being reset
    assign branchM      = r_em.branch & ~stallM & ~rst;
    assign actual_takeM = r_em.actual;
    assign pcM          = r_em.pc;
    assign w_mis_inc    = branchM & r_em.mispred;

    sat_counter #(.W(CNT_W)) u_br_cnt (
        .clk (clk),
        .rst (rst),
        .inc (branchM),
        .q   (br_cnt)
    );

    sat_counter #(.W(CNT_W)) u_mis_cnt (
        .clk (clk),
        .rst (rst),
        .inc (w_mis_inc),
        .q   (mispred_cnt)
    );
endmodule

// File: tb/tb_branch_resolve_local.sv
// Bench for branch_resolve_local: scoreboard of expected M-stage updates,
// narrow counters so saturation is reachable.
module tb_branch_resolve_local;
    localparam int CNT_W = 4;

    logic              clk = 1'b0;
    logic              rst, stallE, flushE, stallM, flushM;
    logic              branchD, pred_takeD, actual_takeE;
    logic [31:0]       pcD, targetD;
    logic              mispredictE, branchM, actual_takeM;
    logic [31:0]       redirect_pcE, pcM;
    logic [CNT_W-1:0]  br_cnt, mispred_cnt;

    typedef struct {
        logic        act;
        logic [31:0] pc;
        logic        mis;
    } upd_t;

    upd_t             q[$];
    int               checks = 0;
    int               errors = 0;
    int               pulses = 0;
    logic [CNT_W-1:0] exp_br = '0;
    logic [CNT_W-1:0] exp_mis = '0;

    always #5 clk = ~clk;

    branch_resolve_local #(.DELAY_SLOT(1), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallE       (stallE),
        .flushE       (flushE),
        .stallM       (stallM),
        .flushM       (flushM),
        .branchD      (branchD),
        .pred_takeD   (pred_takeD),
        .pcD          (pcD),
        .targetD      (targetD),
        .actual_takeE (actual_takeE),
        .mispredictE  (mispredictE),
        .redirect_pcE (redirect_pcE),
        .branchM      (branchM),
        .actual_takeM (actual_takeM),
        .pcM          (pcM),
        .br_cnt       (br_cnt),
        .mispred_cnt  (mispred_cnt)
    );

    // Scoreboard consumer: called at the negedge of every cycle
    task automatic mon();
        upd_t e;
        if (branchM === 1'b1) begin
            pulses++;
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL update_unexpected: got pulse pc=%h, none expected", pcM);
            end else begin
                e = q.pop_front();
                if (actual_takeM !== e.act || pcM !== e.pc) begin
                    errors++;
                    $display("FAIL update_data: got act=%b pc=%h, expected act=%b pc=%h",
                             actual_takeM, pcM, e.act, e.pc);
                end
                if (exp_br != {CNT_W{1'b1}}) exp_br++;
                if (e.mis && exp_mis != {CNT_W{1'b1}}) exp_mis++;
            end
        end
    endtask

    task automatic finish_cycle();
        mon();
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        finish_cycle();
    endtask

    // Put a branch into D and advance it into E
    task automatic load_e(input logic pred, input logic [31:0] pc, input logic [31:0] tgt);
        branchD = 1'b1; pred_takeD = pred; pcD = pc; targetD = tgt;
        step();
        branchD = 1'b0;
    endtask

    // Present the ALU outcome for the E occupant and record the expected update
    task automatic resolve(input logic act, input logic pred, input logic [31:0] pc,
                           input logic push);
        actual_takeE = act;
        if (push) q.push_back('{act: act, pc: pc, mis: pred ^ act});
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        checks += 6;
        if (mispredictE !== 1'b0) begin errors++; $display("FAIL reset_mispredictE: got %b want 0", mispredictE); end
        if (branchM !== 1'b0) begin errors++; $display("FAIL reset_branchM: got %b want 0", branchM); end
        if (br_cnt !== '0) begin errors++; $display("FAIL reset_br_cnt: got %0d want 0", br_cnt); end
        if (mispred_cnt !== '0) begin errors++; $display("FAIL reset_mispred_cnt: got %0d want 0", mispred_cnt); end
        if (actual_takeM !== 1'b0) begin errors++; $display("FAIL reset_actual_takeM: got %b want 0", actual_takeM); end
        if (pcM !== 32'h0) begin errors++; $display("FAIL reset_pcM: got %h want 0", pcM); end
        finish_cycle();
    endtask

    task automatic test_correct_predict();
        load_e(1'b1, 32'h100, 32'h200);
        resolve(1'b1, 1'b1, 32'h100, 1'b1);
        @(negedge clk);
        checks++;
        if (mispredictE !== 1'b0) begin errors++; $display("FAIL correct_mispredictE: got %b want 0", mispredictE); end
        finish_cycle();
        actual_takeE = 1'b0;
        @(negedge clk);
        checks += 3;
        if (branchM !== 1'b1) begin errors++; $display("FAIL correct_branchM: got %b want 1", branchM); end
        if (actual_takeM !== 1'b1) begin errors++; $display("FAIL correct_actual_takeM: got %b want 1", actual_takeM); end
        if (pcM !== 32'h100) begin errors++; $display("FAIL correct_pcM: got %h want 00000100", pcM); end
        finish_cycle();
        @(negedge clk);
        checks += 2;
        if (br_cnt !== exp_br) begin errors++; $display("FAIL correct_br_cnt: got %0d want %0d", br_cnt, exp_br); end
        if (mispred_cnt !== exp_mis) begin errors++; $display("FAIL correct_mispred_cnt: got %0d want %0d", mispred_cnt, exp_mis); end
        finish_cycle();
    endtask

    task automatic test_mispredict();
        load_e(1'b0, 32'h300, 32'h400);
        resolve(1'b1, 1'b0, 32'h300, 1'b1);
        @(negedge clk);
        checks += 2;
        if (mispredictE !== 1'b1) begin errors++; $display("FAIL mis_taken_flag: got %b want 1", mispredictE); end
        if (redirect_pcE !== 32'h400) begin errors++; $display("FAIL mis_taken_pc: got %h want 00000400", redirect_pcE); end
        finish_cycle();
        load_e(1'b1, 32'h100, 32'h180);
        resolve(1'b0, 1'b1, 32'h100, 1'b1);
        @(negedge clk);
        checks += 2;
        if (mispredictE !== 1'b1) begin errors++; $display("FAIL mis_fallthru_flag: got %b want 1", mispredictE); end
        if (redirect_pcE !== 32'h108) begin errors++; $display("FAIL mis_fallthru_pc: got %h want 00000108", redirect_pcE); end
        finish_cycle();
        load_e(1'b1, 32'hFFFF_FFFC, 32'h10);
        resolve(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        @(negedge clk);
        checks++;
        if (redirect_pcE !== 32'h4) begin errors++; $display("FAIL mis_wrap_pc: got %h want 00000004", redirect_pcE); end
        finish_cycle();
        actual_takeE = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_stall_e();
        int p0;
        p0 = pulses;
        load_e(1'b0, 32'h40, 32'h300);
        stallE = 1'b1;
        resolve(1'b1, 1'b0, 32'h40, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks += 2;
            if (mispredictE !== (i == 0)) begin errors++; $display("FAIL stallE_pulse[%0d]: got %b want %b", i, mispredictE, (i == 0)); end
            if (branchM !== 1'b0) begin errors++; $display("FAIL stallE_noupd[%0d]: got %b want 0", i, branchM); end
            finish_cycle();
        end
        stallE = 1'b0;
        @(negedge clk);
        checks++;
        if (mispredictE !== 1'b0) begin errors++; $display("FAIL stallE_release: got %b want 0", mispredictE); end
        finish_cycle();
        actual_takeE = 1'b0;
        repeat (2) step();
        checks++;
        if (pulses - p0 !== 1) begin errors++; $display("FAIL stallE_pulses: got %0d want 1", pulses - p0); end
    endtask

    task automatic test_stall_m();
        int p0;
        p0 = pulses;
        load_e(1'b1, 32'h500, 32'h600);
        resolve(1'b1, 1'b1, 32'h500, 1'b1);
        step();
        actual_takeE = 1'b0;
        stallM = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (branchM !== 1'b0) begin errors++; $display("FAIL stallM_hold[%0d]: got %b want 0", i, branchM); end
            finish_cycle();
        end
        stallM = 1'b0;
        @(negedge clk);
        checks++;
        if (branchM !== 1'b1) begin errors++; $display("FAIL stallM_release: got %b want 1", branchM); end
        finish_cycle();
        @(negedge clk);
        checks += 2;
        if (branchM !== 1'b0) begin errors++; $display("FAIL stallM_after: got %b want 0", branchM); end
        if (pulses - p0 !== 1) begin errors++; $display("FAIL stallM_pulses: got %0d want 1", pulses - p0); end
        finish_cycle();
        // branch held in M, then flushed: it must never report
        p0 = pulses;
        load_e(1'b1, 32'h700, 32'h800);
        resolve(1'b1, 1'b1, 32'h700, 1'b0);
        step();
        actual_takeE = 1'b0;
        stallM = 1'b1;
        step();
        flushM = 1'b1;
        step();
        flushM = 1'b0;
        stallM = 1'b0;
        @(negedge clk);
        checks += 2;
        if (branchM !== 1'b0) begin errors++; $display("FAIL flushM_nopulse: got %b want 0", branchM); end
        if (pulses - p0 !== 0) begin errors++; $display("FAIL flushM_pulses: got %0d want 0", pulses - p0); end
        finish_cycle();
    endtask

    task automatic test_flush_same_cycle();
        load_e(1'b0, 32'h900, 32'hA00);
        resolve(1'b1, 1'b0, 32'h900, 1'b1);
        flushE = 1'b1;
        branchD = 1'b1; pred_takeD = 1'b1; pcD = 32'hB00; targetD = 32'hC00;
        @(negedge clk);
        checks += 2;
        if (mispredictE !== 1'b1) begin errors++; $display("FAIL flushE_mis: got %b want 1", mispredictE); end
        if (redirect_pcE !== 32'hA00) begin errors++; $display("FAIL flushE_pc: got %h want 00000a00", redirect_pcE); end
        finish_cycle();
        flushE = 1'b0;
        branchD = 1'b0;
        @(negedge clk);
        checks++;
        if (mispredictE !== 1'b0) begin errors++; $display("FAIL flushE_bubble: got %b want 0", mispredictE); end
        finish_cycle();
        actual_takeE = 1'b0;
        repeat (2) step();
    endtask

    task automatic test_back_to_back();
        logic        pr[4]  = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        ac[4]  = '{1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] pc[4]  = '{32'h2000, 32'h2004, 32'h2008, 32'h200C};
        logic [31:0] tg[4]  = '{32'h3000, 32'h3100, 32'h3200, 32'h3300};
        logic [31:0] rp;
        for (int i = 0; i <= 4; i++) begin
            branchD = (i < 4);
            if (i < 4) begin
                pred_takeD = pr[i]; pcD = pc[i]; targetD = tg[i];
            end
            if (i > 0) resolve(ac[i-1], pr[i-1], pc[i-1], 1'b1);
            @(negedge clk);
            if (i > 0) begin
                rp = ac[i-1] ? tg[i-1] : pc[i-1] + 32'd8;
                checks++;
                if (mispredictE !== (pr[i-1] ^ ac[i-1])) begin
                    errors++; $display("FAIL b2b_mis[%0d]: got %b want %b", i - 1, mispredictE, pr[i-1] ^ ac[i-1]);
                end
                if (pr[i-1] ^ ac[i-1]) begin
                    checks++;
                    if (redirect_pcE !== rp) begin errors++; $display("FAIL b2b_pc[%0d]: got %h want %h", i - 1, redirect_pcE, rp); end
                end
            end
            finish_cycle();
        end
        branchD = 1'b0;
        actual_takeE = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks += 2;
        if (br_cnt !== exp_br) begin errors++; $display("FAIL b2b_br_cnt: got %0d want %0d", br_cnt, exp_br); end
        if (mispred_cnt !== exp_mis) begin errors++; $display("FAIL b2b_mispred_cnt: got %0d want %0d", mispred_cnt, exp_mis); end
        finish_cycle();
    endtask

    task automatic test_reset_mid();
        load_e(1'b1, 32'h1000, 32'h1100);
        resolve(1'b1, 1'b1, 32'h1000, 1'b0);
        step();
        actual_takeE = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (branchM !== 1'b0) begin errors++; $display("FAIL rstmid_pulse: got %b want 0", branchM); end
        finish_cycle();
        rst = 1'b0;
        exp_br = '0;
        exp_mis = '0;
        @(negedge clk);
        checks += 3;
        if (br_cnt !== '0) begin errors++; $display("FAIL rstmid_br_cnt: got %0d want 0", br_cnt); end
        if (mispred_cnt !== '0) begin errors++; $display("FAIL rstmid_mispred_cnt: got %0d want 0", mispred_cnt); end
        if (pcM !== 32'h0) begin errors++; $display("FAIL rstmid_pcM: got %h want 0", pcM); end
        finish_cycle();
    endtask

    task automatic test_saturate();
        for (int i = 0; i <= 20; i++) begin
            branchD = (i < 20);
            pred_takeD = 1'b0;
            pcD = 32'h4000 + 32'(i) * 32'd16;
            targetD = 32'h8000;
            if (i > 0) resolve(1'b1, 1'b0, 32'h4000 + 32'(i - 1) * 32'd16, 1'b1);
            step();
        end
        branchD = 1'b0;
        actual_takeE = 1'b0;
        repeat (3) step();
        @(negedge clk);
        checks += 4;
        if (mispred_cnt !== 4'hF) begin errors++; $display("FAIL sat_mispred_cnt: got %h want f", mispred_cnt); end
        if (br_cnt !== 4'hF) begin errors++; $display("FAIL sat_br_cnt: got %h want f", br_cnt); end
        if (mispred_cnt !== exp_mis) begin errors++; $display("FAIL sat_mispred_model: got %h want %h", mispred_cnt, exp_mis); end
        if (br_cnt !== exp_br) begin errors++; $display("FAIL sat_br_model: got %h want %h", br_cnt, exp_br); end
        finish_cycle();
    endtask

    initial begin
        rst = 1'b1; stallE = 1'b0; flushE = 1'b0; stallM = 1'b0; flushM = 1'b0;
        branchD = 1'b0; pred_takeD = 1'b0; pcD = '0; targetD = '0; actual_takeE = 1'b0;
        test_reset();
        test_correct_predict();
        test_mispredict();
        test_stall_e();
        test_stall_m();
        test_flush_same_cycle();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        checks++;
        if (q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d updates never seen, want 0", q.size()); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
